mem_port_arbiter: RTL and testbench

// Shares the single-ported unified instruction/data memory of the MIPS pipeline between the
// IF stage (fetch) and the MEM stage (load/store). It holds at most one memory transaction
// in flight, drives pipeline stalls while a requester waits, and halts on a memory timeout.
// It sits between the pipeline stages and the memory model, under the pipeline top.

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/arb_sat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the IF/MEM memory-port arbiter.
package mips_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        ERR
    } arb_state_t;

    // Bits needed to hold 0..limit; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; sat is high while count equals LIMIT.
module arb_sat_counter #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != LIM)
            count <= count + 1'b1;
    end

    assign sat = (count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one transaction in flight, with starvation guard for IF and a sticky timeout.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64,
    localparam int BW          = DW / 8
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [BW-1:0] dm_be,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [BW-1:0] mem_be,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err_timeout
);

    localparam bit TO_EN    = (TIMEOUT != 0);
    localparam int WAIT_LIM = TO_EN ? TIMEOUT - 1 : 1;
    localparam int WAIT_W   = cnt_width(WAIT_LIM);
    localparam int STARVE_W = cnt_width(STARVE_LIMIT);

    arb_state_t state;

    logic busy;
    logic grant_dm;
    logic grant_if;
    logic starve_sat;
    logic wait_sat;
    logic timeout_hit;

    assign busy = (state == BUSY_IF) || (state == BUSY_DM);

    // DM wins ties until it has taken STARVE_LIMIT grants past a waiting fetch.
    assign grant_dm = (state == IDLE) && dm_req && (!if_req || !starve_sat);
    assign grant_if = (state == IDLE) && if_req && !grant_dm;

    assign timeout_hit = TO_EN && busy && !mem_ack && wait_sat;

    arb_sat_counter #(
        .WIDTH (STARVE_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (grant_if),
        .inc   (grant_dm && if_req),
        .sat   (starve_sat)
    );

    arb_sat_counter #(
        .WIDTH (WAIT_W),
        .LIMIT (WAIT_LIM)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (grant_dm || grant_if),
        .inc   (busy && !mem_ack),
        .sat   (wait_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= BUSY_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                    end else if (grant_if) begin
                        state     <= BUSY_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (timeout_hit) begin
                        state       <= ERR;
                        mem_req     <= 1'b0;
                        err_timeout <= 1'b1;
                    end
                end
                ERR: begin
                    // Terminal until reset; acks and requests are ignored.
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_valid = (state == BUSY_IF) && mem_ack;
    assign dm_valid = (state == BUSY_DM) && mem_ack;
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = (dm_valid && !mem_we) ? mem_rdata : '0;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: drivers push expected responses, a monitor pops them on each valid,
// and a behavioural memory answers mem_req with configurable wait states.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err_timeout;

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    // >=0 fixed waits, -1 random 0..3, -2 never ack, -3 ack held high
    int mem_mode = -3;

    logic [31:0] if_exp[$];
    logic [31:0] dm_exp[$];
    int          grant_src[$];   // 0 = IF, 1 = DM
    int          grant_cyc[$];
    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] ref_arr[logic [31:0]];

    logic [31:0] if_cur_addr = '0;
    logic [31:0] dm_cur_addr = '0;
    logic [31:0] dm_cur_wdata = '0;
    logic        dm_cur_we = 1'b0;
    logic [3:0]  dm_cur_be = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_arr.exists(a) ? ref_arr[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Behavioural memory: sees each new transaction one tick after the grant edge.
    initial begin
        bit          in_txn;
        bit          stable_ok;
        int          w;
        logic [31:0] cap_addr, cap_wdata;
        logic        cap_we;
        logic [3:0]  cap_be;
        in_txn = 0;
        stable_ok = 1;
        w = 0;
        cap_addr = '0; cap_wdata = '0; cap_we = 1'b0; cap_be = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset || !mem_req) begin
                in_txn = 0;
                mem_ack = (mem_mode == -3);
                mem_rdata = $urandom;
            end else begin
                if (!in_txn) begin
                    in_txn = 1;
                    stable_ok = 1;
                    cap_addr = mem_addr; cap_wdata = mem_wdata;
                    cap_we = mem_we; cap_be = mem_be;
                    w = (mem_mode == -1) ? int'($urandom_range(0, 3)) : mem_mode;
                    grant_cyc.push_back(cyc);
                    if (if_req && mem_addr == if_cur_addr) begin
                        grant_src.push_back(0);
                        chk("if_grant_we_be", {27'd0, mem_we, mem_be}, {27'd0, 1'b0, 4'hF});
                    end else begin
                        grant_src.push_back(1);
                        chk("dm_grant_addr", mem_addr, dm_cur_addr);
                        chk("dm_grant_we_be", {27'd0, mem_we, mem_be},
                            {27'd0, dm_cur_we, dm_cur_be});
                        if (dm_cur_we) chk("dm_grant_wdata", mem_wdata, dm_cur_wdata);
                    end
                end else if ({mem_addr, mem_we, mem_wdata, mem_be} !=
                             {cap_addr, cap_we, cap_wdata, cap_be}) begin
                    stable_ok = 0;
                end
                if (mem_mode == -2) begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end else if (mem_mode == -3) begin
                    mem_ack = 1'b1;
                    mem_rdata = $urandom;
                end else if (w == 0) begin
                    mem_ack = 1'b1;
                    chk("mem_bus_stable", {31'd0, stable_ok}, 32'd1);
                    if (mem_we) begin
                        mem_arr[mem_addr] = merge(mem_rd(mem_addr), mem_wdata, mem_be);
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                    end
                end else begin
                    w--;
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a valid is presented.
    always @(negedge clk) begin
        if (reset) begin
            if (if_valid) begin
                if (if_exp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL if_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else chk("if_rdata", if_rdata, if_exp.pop_front());
            end
            if (dm_valid) begin
                if (dm_exp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dm_valid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else chk("dm_rdata", dm_rdata, dm_exp.pop_front());
            end
            chk("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~if_valid});
            chk("stall_mem", {31'd0, stall_mem}, {31'd0, dm_req & ~dm_valid});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for the requester's valid, then returns at the following drive point.
    task automatic wait_valid(input bit is_if);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (is_if ? if_valid : dm_valid) break;
            n++;
            if (n > 100) begin
                total++; bad++;
                $display("FAIL %s_wait: got no valid expected valid within 100 cycles",
                         is_if ? "if" : "dm");
                break;
            end
        end
        tick();
    endtask

    task automatic do_if(input logic [31:0] a);
        if_req = 1'b1;
        if_addr = a;
        if_cur_addr = a;
        if_exp.push_back(ref_rd(a));
        wait_valid(1'b1);
    endtask

    task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
        dm_req = 1'b1;
        dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
        dm_cur_we = we; dm_cur_addr = a; dm_cur_wdata = wd; dm_cur_be = be;
        if (we) begin
            ref_arr[a] = merge(ref_rd(a), wd, be);
            dm_exp.push_back(32'd0);
        end else begin
            dm_exp.push_back(ref_rd(a));
        end
        wait_valid(1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500us");
        $fatal(1);
    end

    initial begin
        int exp_order[6];
        exp_order = '{1, 1, 1, 1, 0, 1};
        mem_arr[32'h40] = 32'h2008000A;
        ref_arr[32'h40] = 32'h2008000A;

        // Reset state, with mem_ack held high to show it cannot produce a valid.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_bus", mem_addr | mem_wdata | {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_valid", {30'd0, if_valid, dm_valid}, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        mem_mode = 0;
        tick();
        reset = 1'b1;

        // 1: reset aborts an in-flight DM transaction.
        mem_mode = -2;
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'hF;
        dm_cur_we = 1'b0; dm_cur_addr = 32'h200; dm_cur_be = 4'hF;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t1_granted", {31'd0, mem_req}, 32'd1);
        tick();
        #2;
        reset = 1'b0;
        dm_req = 1'b0;
        #1;
        chk("t1_async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t1_no_valid", {30'd0, if_valid, dm_valid}, 32'd0);
        mem_mode = 0;
        tick();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_idle_after", {31'd0, mem_req}, 32'd0);
        end

        // 2: zero-wait fetch.
        tick();
        if_req = 1'b1; if_addr = 32'h40; if_cur_addr = 32'h40;
        if_exp.push_back(ref_rd(32'h40));
        @(negedge clk);
        chk("t2_stall_c0", {31'd0, stall_if}, 32'd1);
        chk("t2_mem_req_c0", {31'd0, mem_req}, 32'd0);
        tick();
        @(negedge clk);
        chk("t2_mem_req_c1", {31'd0, mem_req}, 32'd1);
        chk("t2_valid_c1", {31'd0, if_valid}, 32'd1);
        chk("t2_stall_c1", {31'd0, stall_if}, 32'd0);
        chk("t2_rdata", if_rdata, 32'h2008000A);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        chk("t2_mem_req_c2", {31'd0, mem_req}, 32'd0);

        // 3: store with three wait states; requester inputs wiggle mid-flight.
        mem_mode = 3;
        tick();
        do_dm_issue_store();
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) begin
                dm_wdata = 32'h12345678; dm_addr = 32'h104; dm_be = 4'hF;
            end
            @(negedge clk);
            chk("t3_mem_req", {31'd0, mem_req}, 32'd1);
            chk("t3_mem_addr", mem_addr, 32'h100);
            chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
            chk("t3_mem_we_be", {27'd0, mem_we, mem_be}, {27'd0, 1'b1, 4'b0011});
            chk("t3_dm_valid", {31'd0, dm_valid}, (k == 4) ? 32'd1 : 32'd0);
        end
        tick();
        dm_req = 1'b0;
        @(negedge clk);
        chk("t3_mem_req_done", {31'd0, mem_req}, 32'd0);

        // 4: starvation guard with both requesters held.
        mem_mode = 0;
        tick();
        grant_src.delete();
        fork
            begin
                do_if(32'h4000_0100);
                if_req = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++)
                    do_dm(1'b0, 32'h1000_0000 + 32'(4 * i), 32'd0, 4'hF);
                dm_req = 1'b0;
            end
        join
        chk("t4_grant_count", grant_src.size(), 32'd6);
        for (int i = 0; i < 6 && i < grant_src.size(); i++)
            chk($sformatf("t4_grant_%0d", i), grant_src[i], exp_order[i]);

        // 6: simultaneous fresh requests with the starve counter clear.
        tick();
        grant_src.delete();
        grant_cyc.delete();
        fork
            begin
                do_if(32'h4000_0200);
                if_req = 1'b0;
            end
            begin
                do_dm(1'b1, 32'h1000_0040, $urandom, 4'(($urandom_range(1, 15))));
                dm_req = 1'b0;
            end
        join
        chk("t6_grant_count", grant_src.size(), 32'd2);
        if (grant_src.size() == 2) begin
            chk("t6_first_dm", grant_src[0], 32'd1);
            chk("t6_second_if", grant_src[1], 32'd0);
            chk("t6_gap", grant_cyc[1] - grant_cyc[0], 32'd2);
        end

        // Randomized traffic against the reference memory.
        mem_mode = -1;
        tick();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    do_if(32'h4000_0000 + 32'(4 * $urandom_range(0, 63)));
                    if ($urandom_range(0, 1) == 1) begin
                        if_req = 1'b0;
                        repeat ($urandom_range(0, 2)) tick();
                    end
                end
                if_req = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    do_dm(1'($urandom_range(0, 1)), 32'h1000_0000 + 32'(4 * $urandom_range(0, 7)),
                          $urandom, 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 1) == 1) begin
                        dm_req = 1'b0;
                        repeat ($urandom_range(0, 2)) tick();
                    end
                end
                dm_req = 1'b0;
            end
        join
        repeat (3) tick();
        chk("rand_if_drained", if_exp.size(), 32'd0);
        chk("rand_dm_drained", dm_exp.size(), 32'd0);

        // 5: timeout into ERR, then no grants and late acks ignored.
        mem_mode = -2;
        tick();
        if_req = 1'b1; if_addr = 32'h4000_0300; if_cur_addr = 32'h4000_0300;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) begin
                chk("t5_busy_c8", {31'd0, mem_req}, 32'd1);
                chk("t5_err_c8", {31'd0, err_timeout}, 32'd0);
            end
            tick();
        end
        @(negedge clk);
        chk("t5_mem_req_err", {31'd0, mem_req}, 32'd0);
        chk("t5_err_set", {31'd0, err_timeout}, 32'd1);
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000_0000;
        mem_mode = -3;
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_grant", {31'd0, mem_req}, 32'd0);
            chk("t5_no_valid", {30'd0, if_valid, dm_valid}, 32'd0);
            chk("t5_stalls", {30'd0, stall_if, stall_mem}, 32'd3);
            chk("t5_err_sticky", {31'd0, err_timeout}, 32'd1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Issues the directed store of test 3 without waiting for its completion.
    task automatic do_dm_issue_store;
        dm_req = 1'b1;
        dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
        dm_cur_we = 1'b1; dm_cur_addr = 32'h100; dm_cur_wdata = 32'hDEADBEEF;
        dm_cur_be = 4'b0011;
        ref_arr[32'h100] = merge(ref_rd(32'h100), 32'hDEADBEEF, 4'b0011);
        dm_exp.push_back(32'd0);
    endtask

endmodule
